dec_2to4: RTL and testbench
===========================

Name: dec_2to4

Overview:
- 2-to-4 line binary decoder with active-high enable and active-high one-hot outputs.
- Outputs are registered on the single clock, which gives downstream select logic glitch-free one-hot enables.
- Used as a generic address or select decoder.
- Asynchronous active-low reset forces all outputs inactive.

Parameters:
- OUT_REG, default 1. 1 means Y is registered, with 1-cycle latency. 0 means Y is combinational from A and E, and reset still forces Y to 0 while asserted.

Ports:
- clk  input  1  System clock; all state updates on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- A  input  2  Binary select code; A[1] is the MSB.
- E  input  1  Decoder enable, active high.
- Y  output  4  One-hot decoded output, active high; Y[i] corresponds to code i.

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset:
  - rst_n low forces Y = 4'b0000 immediately, without waiting for a clock edge.
  - Y stays 0 while rst_n is low, for any A and E.
  - Reset deassertion is synchronous in effect: the first decode appears at the first rising clk edge after rst_n goes high (OUT_REG=1).
- Decode function, next_Y:
  - E=0: next_Y = 4'b0000, regardless of A.
  - E=1, A=00: next_Y = 4'b0001 (Y[0]).
  - E=1, A=01: next_Y = 4'b0010 (Y[1]).
  - E=1, A=10: next_Y = 4'b0100 (Y[2]).
  - E=1, A=11: next_Y = 4'b1000 (Y[3]).
- Timing, OUT_REG=1:
  - Y <= next_Y on each rising clk edge.
  - Latency is exactly 1 cycle from A/E sampled at an edge to Y.
  - No other state is held.
- Timing, OUT_REG=0:
  - Y = next_Y combinationally, gated to 0 while rst_n is low.
- Invariants:
  - Y is always one-hot (E=1) or all-zero (E=0 or in reset).
  - Y never has two bits set, in any cycle.
- X/Z on A or E:
  - No X propagation requirement is imposed.
  - The implementation uses a full case with a default of 4'b0000, so an unknown code yields 0 in synthesis.
- Simultaneous events:
  - A and E changing in the same cycle are sampled together; no ordering priority.
  - Reset assertion coincident with a clock edge: reset wins, Y = 0.
  - Reset mid-operation clears Y in the same instant, asynchronously; no pending decode survives reset.
- No handshake; the decoder is always ready.

Test Plan:
- Reset: rst_n=0, E=1, A=11 -> Y=0000 immediately and across several clocks. Release rst_n -> Y=1000 after the next rising edge.
- Disabled: E=0, sweep A=00,01,10,11 -> Y=0000 every cycle.
- Enable sweep: E=1 with A=00 -> Y=0001; then A=01 -> 0010, A=11 -> 1000, A=10 -> 0100. Each value appears exactly 1 cycle after its input is applied.
- Enable drop: E=1, A=10 gives Y=0100; set E=0 -> Y=0000 on the next edge. Re-enable -> Y=0100.
- Async reset mid-stream: E=1, A=01 gives Y=0010; pulse rst_n low between clock edges -> Y=0000 without a clock edge, then Y=0010 one edge after release.
- Invariant check, all OUT_REG values: random A/E/rst_n for 1000 cycles -> Y is all-zero or exactly one bit set. When set, the set bit index equals the A value sampled in the previous cycle (OUT_REG=1) or the current A (OUT_REG=0).

Source files
------------

// File: rtl/dec_2to4.sv
// 2-to-4 one-hot select decoder with active-high enable; Y is all-zero when disabled or in reset.
// Latency 1 cycle (OUT_REG=1) or 0 (OUT_REG=0); no handshake, always accepts input.
module dec_2to4 #(
  parameter int OUT_REG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic       E,
  output logic [3:0] Y
);

  logic [3:0] next_y;

  // Full case with a zero default so an unknown code resolves to no select.
  always_comb begin
    next_y = 4'b0000;
    if (E) begin
      case (A)
        2'b00:   next_y = 4'b0001;
        2'b01:   next_y = 4'b0010;
        2'b10:   next_y = 4'b0100;
        2'b11:   next_y = 4'b1000;
        default: next_y = 4'b0000;
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [3:0] y_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= 4'b0000;
        end else begin
          y_q <= next_y;
        end
      end

      assign Y = y_q;
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk;
      // Reset still masks the output even though nothing is stored.
      assign Y = rst_n ? next_y : 4'b0000;
    end
  endgenerate

endmodule

// File: tb/tb_dec_2to4.sv
// Scoreboard bench for dec_2to4: registered instance checked by a queue-driven monitor,
// combinational instance checked at each input change.
module tb_dec_2to4;

  logic       clk;
  logic       rst_n;
  logic [1:0] A;
  logic       E;
  logic [3:0] Y;
  logic [3:0] Y_c;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  dec_2to4 #(.OUT_REG(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .E    (E),
    .Y    (Y)
  );

  dec_2to4 #(.OUT_REG(0)) dut_c (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .E    (E),
    .Y    (Y_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: registered output is compared after every rising edge that has a pending expectation.
  initial begin
    logic [3:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("reg_y", Y, exp);
        checks++;
        if ($countones(Y) > 1) begin
          errors++;
          $display("FAIL reg_onehot: got %b expected at most one bit set", Y);
        end
      end
    end
  end

  // Apply inputs at the falling edge; exp is the Y the registered instance must show after the
  // next rising edge, which is also what the combinational instance shows right now.
  task automatic drive(input logic [1:0] a, input logic e, input logic [3:0] exp);
    @(negedge clk);
    A = a;
    E = e;
    exp_q.push_back(exp);
    #1;
    check("comb_y", Y_c, exp);
  endtask

  initial begin
    logic [1:0] ra;
    logic       re;
    logic [3:0] rexp;

    rst_n = 1'b0;
    A     = 2'b11;
    E     = 1'b1;
    #1;
    check("reset_imm_reg", Y, 4'b0000);
    check("reset_imm_comb", Y_c, 4'b0000);

    // Held in reset with an active code: outputs stay clear across several edges.
    repeat (3) drive(2'b11, 1'b1, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b1000);
    #1;
    check("release_comb", Y_c, 4'b1000);

    // Disabled sweep.
    drive(2'b00, 1'b0, 4'b0000);
    drive(2'b01, 1'b0, 4'b0000);
    drive(2'b10, 1'b0, 4'b0000);
    drive(2'b11, 1'b0, 4'b0000);

    // Enabled sweep.
    drive(2'b00, 1'b1, 4'b0001);
    drive(2'b01, 1'b1, 4'b0010);
    drive(2'b11, 1'b1, 4'b1000);
    drive(2'b10, 1'b1, 4'b0100);

    // Enable drop and re-enable.
    drive(2'b10, 1'b0, 4'b0000);
    drive(2'b10, 1'b1, 4'b0100);

    // Async reset pulse between edges while decoding code 1.
    drive(2'b01, 1'b1, 4'b0010);
    @(negedge clk);
    exp_q.push_back(4'b0010);
    #1;
    check("pre_pulse_reg", Y, 4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check("pulse_reg", Y, 4'b0000);
    check("pulse_comb", Y_c, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_pulse_comb", Y_c, 4'b0010);

    // Randomised run with occasional whole-cycle resets.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra    = 2'($urandom_range(0, 3));
      re    = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 15) != 0);
      A     = ra;
      E     = re;
      rexp  = (rst_n && re) ? (4'b0001 << ra) : 4'b0000;
      exp_q.push_back(rexp);
      #1;
      check("rand_comb", Y_c, rexp);
    end

    @(negedge clk);
    rst_n = 1'b1;
    E     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
